pipe_ctrl: RTL

//  Pipeline sequencer for the 3-stage RV32I core (F | DE | WB) around the decode/execute stage.

---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Interface between the DE/WB pipeline sequencer and the core datapath.
// The slave side is the sequencer: it observes DE and drives the pipeline controls.
interface pipe_ctrl_if;
   logic [31:0] de_instr;
   logic        de_valid;
   logic        br_taken;
   logic        mem_busy;
   logic        f_en;
   logic        de_en;
   logic        de_kill;
   logic        fwd_a;
   logic        fwd_b;
   logic        wb_wen;
   logic [4:0]  wb_rd;
   logic        wb_is_load;
   logic        wb_csr_load;
   logic [1:0]  state;

   modport master (
      output de_instr, de_valid, br_taken, mem_busy,
      input  f_en, de_en, de_kill, fwd_a, fwd_b, wb_wen, wb_rd, wb_is_load, wb_csr_load, state
   );

   modport slave (
      input  de_instr, de_valid, br_taken, mem_busy,
      output f_en, de_en, de_kill, fwd_a, fwd_b, wb_wen, wb_rd, wb_is_load, wb_csr_load, state
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 3-stage RV32I core: load-use stalls, branch flushes,
// memory-busy freezes, WB->DE forwarding and regfile/CSR write strobes.
//
// state   | meaning
// BOOT    | first cycle after reset, fetch held off, DE squashed
// RUN     | normal flow, DE advances into WB each cycle
// LDUSE   | extra load-use stall cycles after the detect cycle
// BRFLUSH | DE holds wrong-path instructions after a taken branch
module pipe_ctrl #(
   parameter int LOAD_LAT   = 1,
   parameter int BR_PENALTY = 1
) (
   input logic       clk,
   input logic       reset,
   pipe_ctrl_if.slave bus
);
   localparam int MAXC = (LOAD_LAT > BR_PENALTY) ? LOAD_LAT : BR_PENALTY;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   // The detect cycle is itself a stall, so LDUSE only covers the remaining LOAD_LAT-1.
   localparam logic [CW-1:0] LD_INIT = (LOAD_LAT > 1) ? CW'(LOAD_LAT - 2) : '0;
   localparam logic [CW-1:0] BR_INIT = CW'(BR_PENALTY - 1);

   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, LDUSE = 2'd2, BRFLUSH = 2'd3} state_t;
   typedef enum logic [1:0] {WB_HOLD, WB_CAP, WB_BUB} wb_op_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   wb_op_t        wb_op;

   logic       wb_valid, wb_wr, wb_is_load, wb_csr;
   logic [4:0] wb_rd;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rd, rs1, rs2;
   logic op_r, op_i, op_ld, op_st, op_br, op_jal, op_jalr, op_lui, op_auipc, op_sys;
   logic uses_rs1, uses_rs2, writes, is_csr;
   logic dv, hz, rs1_hit, rs2_hit, wb_fwdable;

   assign opcode = bus.de_instr[6:0];
   assign funct3 = bus.de_instr[14:12];
   assign rd     = bus.de_instr[11:7];
   assign rs1    = bus.de_instr[19:15];
   assign rs2    = bus.de_instr[24:20];

   assign op_r     = (opcode == 7'b0110011);
   assign op_i     = (opcode == 7'b0010011);
   assign op_ld    = (opcode == 7'b0000011);
   assign op_st    = (opcode == 7'b0100011);
   assign op_br    = (opcode == 7'b1100011);
   assign op_jal   = (opcode == 7'b1101111);
   assign op_jalr  = (opcode == 7'b1100111);
   assign op_lui   = (opcode == 7'b0110111);
   assign op_auipc = (opcode == 7'b0010111);
   assign op_sys   = (opcode == 7'b1110011);

   assign uses_rs1 = op_r | op_i | op_ld | op_st | op_br | op_jalr | (op_sys & (funct3 == 3'b001));
   assign uses_rs2 = op_r | op_st | op_br;
   assign writes   = (op_r | op_i | op_ld | op_lui | op_auipc | op_jal | op_jalr) & (rd != 5'd0);
   assign is_csr   = op_sys & ((funct3 == 3'b001) | (funct3 == 3'b101))
                     & (bus.de_instr[31:20] == 12'h51E);

   assign dv         = bus.de_valid & (state != BRFLUSH);
   assign rs1_hit    = uses_rs1 & (rs1 == wb_rd);
   assign rs2_hit    = uses_rs2 & (rs2 == wb_rd);
   assign hz         = dv & wb_valid & wb_is_load & (wb_rd != 5'd0) & (rs1_hit | rs2_hit);
   assign wb_fwdable = dv & wb_valid & wb_wr & ~wb_is_load & (wb_rd != 5'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= BOOT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid   <= 1'b0;
         wb_wr      <= 1'b0;
         wb_rd      <= 5'd0;
         wb_is_load <= 1'b0;
         wb_csr     <= 1'b0;
      end else if (wb_op == WB_CAP) begin
         wb_valid   <= 1'b1;
         wb_wr      <= writes;
         wb_rd      <= rd;
         wb_is_load <= op_ld;
         wb_csr     <= is_csr;
      end else if (wb_op == WB_BUB) begin
         wb_valid   <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wb_op     = WB_HOLD;
      if (!bus.mem_busy) begin
         case (state)
            BOOT: begin
               state_nxt = RUN;
               wb_op     = WB_BUB;
            end
            RUN: begin
               if (hz) begin
                  wb_op = WB_BUB;
                  if (LOAD_LAT > 1) begin
                     state_nxt = LDUSE;
                     cnt_nxt   = LD_INIT;
                  end
               end else if (dv && bus.br_taken) begin
                  wb_op     = WB_CAP;
                  state_nxt = BRFLUSH;
                  cnt_nxt   = BR_INIT;
               end else begin
                  wb_op = dv ? WB_CAP : WB_BUB;
               end
            end
            LDUSE, BRFLUSH: begin
               wb_op = WB_BUB;
               if (cnt == '0) state_nxt = RUN;
               else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = BOOT;
         endcase
      end
   end

   always_comb begin
      bus.f_en    = 1'b0;
      bus.de_kill = 1'b0;
      case (state)
         BOOT:    bus.de_kill = 1'b1;
         RUN:     bus.f_en    = ~hz;
         LDUSE:   bus.f_en    = 1'b0;
         BRFLUSH: begin
            bus.f_en    = 1'b1;
            bus.de_kill = 1'b1;
         end
         default: bus.de_kill = 1'b1;
      endcase
      if (bus.mem_busy) bus.f_en = 1'b0;
      bus.de_en       = bus.f_en;
      bus.fwd_a       = wb_fwdable & rs1_hit;
      bus.fwd_b       = wb_fwdable & rs2_hit;
      bus.wb_wen      = wb_valid & wb_wr & ~bus.mem_busy;
      bus.wb_csr_load = wb_valid & wb_csr & ~bus.mem_busy;
   end

   assign bus.wb_rd      = wb_rd;
   assign bus.wb_is_load = wb_is_load;
   assign bus.state      = state;
endmodule
